// File: rtl/mdr_sqrt.sv
// Iterative restoring integer square root: DW/2 iterations, 2 radicand bits per step.
// Optional abort input enabled by defining MDR_SQRT_ABORT_EN.
module mdr_sqrt #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_data,
`ifdef MDR_SQRT_ABORT_EN
  input  logic          i_abort,
`endif
  output logic [DW-1:0] o_root,
  output logic [DW-1:0] o_rem,
  output logic          o_busy,
  output logic          o_done
);
  localparam int HW = DW / 2;
  localparam int CW = $clog2(HW) + 1;

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t        r_state;
  logic [DW-1:0] r_opnd;
  logic [HW+1:0] r_rem_w;
  logic [HW-1:0] r_root_w;
  logic [CW-1:0] r_cnt;

  logic [HW+1:0] w_r;
  logic [HW+1:0] w_t;
  logic [HW+1:0] w_rem_nx;
  logic [HW-1:0] w_root_nx;
  logic          w_abort;

`ifdef MDR_SQRT_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // r needs the full HW+2 bits; the partial remainder never exceeds 2*root.
  assign w_r = (r_rem_w << 2) | {{HW{1'b0}}, r_opnd[DW-1 -: 2]};
  assign w_t = {r_root_w, 2'b01};

  always_comb begin
    w_rem_nx  = w_r;
    w_root_nx = {r_root_w[HW-2:0], 1'b0};
    if (w_r >= w_t) begin
      w_rem_nx  = w_r - w_t;
      w_root_nx = {r_root_w[HW-2:0], 1'b1};
    end
  end

  assign o_busy = (r_state == S_CALC);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_opnd   <= '0;
      r_rem_w  <= '0;
      r_root_w <= '0;
      r_cnt    <= '0;
      o_root   <= '0;
      o_rem    <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_opnd   <= i_data;
            r_rem_w  <= '0;
            r_root_w <= '0;
            r_cnt    <= CW'(HW);
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // Abort wins over the final iteration: results stay untouched.
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_opnd   <= r_opnd << 2;
            r_rem_w  <= w_rem_nx;
            r_root_w <= w_root_nx;
            r_cnt    <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              r_state <= S_IDLE;
              o_root  <= DW'(w_root_nx);
              o_rem   <= DW'(w_rem_nx);
              o_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mdr_sqrt.md
# mdr_sqrt

Iterative integer square-root unit for the MDR datapath: it takes an unsigned operand, computes floor(sqrt) and the remainder over DW/2 clock cycles, and presents registered results. It sits directly upstream of the 3-to-1 result multiplexer and drives its root-operation input. The DW result width matches that multiplexer's data width.

## Interface
Parameters:
- DW, 8: operand and result width; must be even and ≥ 4.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous and active-high.
- i_start  input  1  start request; sampled only in IDLE.
- i_data  input  DW  unsigned radicand; sampled with i_start.
- o_root  output  DW  floor(sqrt(i_data)), zero-extended from DW/2 bits.
- o_rem  output  DW  i_data − o_root², zero-extended from DW/2+1 bits.
- o_busy  output  1  high while state is CALC.
- o_done  output  1  one-cycle pulse when o_root/o_rem update.
- i_abort  input  1  abort the operation in progress; present only with MDR_SQRT_ABORT_EN.

## Operation
- Algorithm: restoring digit-by-digit square root, 2 radicand bits per iteration, DW/2 iterations.
- Working registers:
  - opnd (DW bits): shifted radicand.
  - rem_w (DW/2+2 bits).
  - root_w (DW/2 bits).
  - cnt (clog2(DW/2)+1 bits).
- State machine with two states, IDLE and CALC:
  - IDLE, i_start=1: opnd←i_data, rem_w←0, root_w←0, cnt←DW/2, go to CALC.
  - IDLE, i_start=0: stay in IDLE.
  - CALC: perform one iteration, decrement cnt. If cnt==1, go to IDLE, copy the results to o_root/o_rem, and set o_done for the next cycle.
- Iteration:
  - r = (rem_w<<2) | opnd[DW-1:DW-2]
  - t = (root_w<<2) | 1
  - If r ≥ t: rem_w←r−t, root_w←(root_w<<1)|1.
  - Otherwise: rem_w←r, root_w←root_w<<1.
  - opnd←opnd<<2.
- All comparisons are unsigned. Intermediate widths must not truncate r, which needs DW/2+2 bits.
- o_root and o_rem hold their last result until the next completion. They do not change during CALC.
- i_start while busy is ignored; there is no queueing. i_data is don't-care outside the start cycle.
- Reset values: o_root=0, o_rem=0, o_busy=0, o_done=0, state IDLE, all working registers 0.

## Timing
- Start edge E0 (IDLE, i_start=1) → o_busy=1 from E0 to E(DW/2).
- Iterations occur on edges E1 … E(DW/2).
- At E(DW/2): o_root/o_rem update, o_done=1 for exactly one cycle, o_busy=0.
- Latency from start edge to result: DW/2 edges. With DW=8, results are visible after E4.
- Back-to-back operation: i_start may be high during the o_done cycle. It is accepted, giving a throughput of one result per DW/2+1 cycles.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. No o_done pulse is issued for the lost operation.

## Configuration
- MDR_SQRT_ABORT_EN defined:
  - The i_abort port exists.
  - i_abort=1 in CALC → IDLE on the next edge. o_done is not pulsed, and o_root/o_rem keep their previous values.
  - i_abort has priority over the final-iteration completion.
  - i_abort in IDLE is ignored, including when i_start is high in the same cycle; the start is accepted.
- MDR_SQRT_ABORT_EN undefined: no i_abort port. Every started operation runs to completion.

## Test plan
- DW=8, reset, then i_data=144 with i_start → o_done 4 edges later; o_root=12, o_rem=0; o_busy high for exactly 4 cycles.
- i_data=255 → o_root=15, o_rem=30. i_data=0 → o_root=0, o_rem=0. i_data=200 → o_root=14, o_rem=4.
- Start 100, then pulse i_start with 49 two cycles later → result is 10/0 only; one o_done pulse. Immediate restart with 49 in the o_done cycle → 7/0 after 4 more edges.
- Assert i_rst asynchronously in mid-CALC, between edges → all outputs 0 immediately; no o_done; a fresh start with 81 → 9/0.
- Under MDR_SQRT_ABORT_EN: complete 25 (→5/0), start 225, assert i_abort at E2 → o_busy=0 after E2, no o_done, o_root/o_rem stay 5/0.
- Exhaustive sweep, DW=8, all 256 inputs: check o_root²+o_rem==i_data and o_rem ≤ 2·o_root.
